hilo_md_unit: RTL and testbench
===============================

# hilo_md_unit

Multiply/divide issue controller and HI/LO register pair for the EX stage. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and drives the multi-cycle divider through its start/annul/ready handshake. It stalls the pipeline while a divide is in flight, then commits the 64-bit result into HI/LO. Multiplies and MTHI/MTLO commit in a single cycle.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- flush  in  1  pipeline flush; kills the EX-stage instruction, including an in-flight divide
- op_valid  in  1  EX-stage holds a valid instruction
- op  in  3  1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; all other codes are no-op
- rs_data  in  32  operand A (dividend / multiplicand / MTHI / MTLO source)
- rt_data  in  32  operand B (divisor / multiplier)
- stall_o  out  1  pipeline stall request to the hazard unit
- div_start_o  out  1  divider start, registered
- div_signed_o  out  1  divider signed mode, registered
- div_op1_o  out  32  dividend, registered
- div_op2_o  out  32  divisor, registered
- div_annul_o  out  1  divider cancel; combinational, equals flush
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid
- hi_o  out  32  HI register
- lo_o  out  32  LO register

## Operation
- Reset (rst=0 at an edge): state=IDLE; hi_o, lo_o, div_op1_o, div_op2_o = 0; div_start_o=0; div_signed_o=0. stall_o=0 while in reset.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE, op_valid=1, flush=0:
  - MULT: {HI,LO} <= signed rs*rt, 64-bit product.
  - MULTU: {HI,LO} <= unsigned rs*rt.
  - MTHI: HI <= rs. MTLO: LO <= rs.
  - DIV/DIVU: latch rs/rt into div_op1_o/div_op2_o; div_signed_o <= (op==DIV); div_start_o <= 1; go to BUSY.
- IDLE with flush=1: no writes, no transition.
- BUSY:
  - flush=1 takes priority over div_ready_i: div_start_o <= 0, go to IDLE, HI/LO unchanged.
  - Otherwise, on div_ready_i=1: HI <= div_result_i[63:32], LO <= div_result_i[31:0], div_start_o <= 0, go to DONE.
- DONE:
  - Ignore all inputs; this stops the still-present DIV from re-issuing.
  - Go to IDLE unconditionally.
  - div_start_o stays 0, so the divider returns to its idle state.
- stall_o is combinational:
  - 1 in IDLE when op_valid & !flush & op∈{DIV,DIVU}.
  - 1 in BUSY when !flush.
  - 0 in DONE and in all other cases.
- In BUSY and DONE, op/rs/rt are ignored (the pipeline is frozen).
- Divide by zero is not special-cased. The divider still raises ready, and HI/LO take whatever div_result_i carries.
- div_ready_i is ignored outside BUSY.
- div_annul_o = flush in every state. A flush while the divider sits in its result-hold state is resolved by div_start_o dropping.

## Timing
- MULT/MULTU/MTHI/MTLO: issue in cycle 0; hi_o/lo_o show the new value in cycle 1; no stall.
- DIV/DIVU, non-zero divisor, with the companion divider:
  - Cycle 0: IDLE, stall_o=1.
  - Cycle 1: div_start_o=1.
  - Cycle 36: div_ready_i=1; the commit happens at the end of this cycle.
  - Cycle 37: DONE; HI/LO hold the new value, stall_o=0.
  - Cycle 38: IDLE. A back-to-back DIV may issue here and stalls again starting this cycle.
  - stall_o is high in cycles 0–36 (37 cycles).
- Divide by zero: div_ready_i=1 in cycle 4; stall_o high in cycles 0–4; DONE in cycle 5.
- Flush in BUSY at cycle k: stall_o=0 in cycle k; IDLE and div_start_o=0 from cycle k+1.
- Reset in mid-operation: reset overrides everything on the next edge. The divider is reset by the same rst.

## Test plan
- MULT rs=0xFFFFFFFF, rt=2 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE. stall_o stays 0.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → stall_o high for 37 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2.
- Divider handshake on a DIV:
  - div_start_o stays high until the commit cycle.
  - div_start_o drops in DONE.
  - Holding the DIV on op for an extra cycle does not re-issue a second divide.
- flush asserted 10 cycles into a DIV:
  - div_annul_o=1 and stall_o=0 in that cycle.
  - HI/LO keep their prior values.
  - A following MTHI rs=0x12345678 writes HI=0x12345678.
- DIV rt=0 → stall ends after 5 cycles; the FSM returns to IDLE; a subsequent DIVU 9/3 gives LO=3, HI=0.
- rst=0 asserted mid-divide → next cycle hi_o=lo_o=0, div_start_o=0, stall_o=0, FSM in IDLE. An immediate MTLO rs=5 after release gives LO=5.

Source files
------------

// File: rtl/hilo_md_unit.sv
// HI/LO register pair with multiply/divide issue control for the EX stage.
// Multiplies and MTHI/MTLO commit in one cycle; divides stall until the divider reports ready.
module hilo_md_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        is_div;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    // Extend both operands to 64 bits; the low 64 bits of the product are exact either way.
    always_comb begin
        is_div     = (op == OP_DIV) || (op == OP_DIVU);
        mul_signed = (op == OP_MULT);
        mul_a      = {{32{mul_signed & rs_data[31]}}, rs_data};
        mul_b      = {{32{mul_signed & rt_data[31]}}, rt_data};
        product    = mul_a * mul_b;
    end

    assign stall_o     = rst && !flush &&
                         (((state == IDLE) && op_valid && is_div) || (state == BUSY));
    assign div_annul_o = flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            hi_o         <= '0;
            lo_o         <= '0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: {hi_o, lo_o} <= product;
                            OP_DIV, OP_DIVU: begin
                                div_op1_o    <= rs_data;
                                div_op2_o    <= rt_data;
                                div_signed_o <= (op == OP_DIV);
                                div_start_o  <= 1'b1;
                                state        <= BUSY;
                            end
                            OP_MTHI: hi_o <= rs_data;
                            OP_MTLO: lo_o <= rs_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (flush) begin
                        div_start_o <= 1'b0;
                        state       <= IDLE;
                    end else if (div_ready_i) begin
                        hi_o        <= div_result_i[63:32];
                        lo_o        <= div_result_i[31:0];
                        div_start_o <= 1'b0;
                        state       <= DONE;
                    end
                end
                // One dead cycle so the still-present DIV in EX is not issued again.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit with a behavioural stand-in for the multi-cycle divider.
module tb_hilo_md_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_annul_o;
    logic [63:0] div_result_i = '0;
    logic        div_ready_i = 1'b0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    hilo_md_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .stall_o(stall_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_annul_o(div_annul_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Divider stand-in: ready in the 35th cycle after start rises (3rd for a zero divisor),
    // then holds its result until start drops.
    logic [5:0]  dcnt = '0;
    logic [31:0] q_m;
    logic [31:0] r_m;
    always_comb begin
        if (div_op2_o == 32'd0) begin
            q_m = '1;
            r_m = div_op1_o;
        end else if (div_signed_o) begin
            q_m = 32'($signed(div_op1_o) / $signed(div_op2_o));
            r_m = 32'($signed(div_op1_o) % $signed(div_op2_o));
        end else begin
            q_m = div_op1_o / div_op2_o;
            r_m = div_op1_o % div_op2_o;
        end
    end
    always @(posedge clk) begin
        if (!rst || !div_start_o || div_annul_o) begin
            dcnt        <= '0;
            div_ready_i <= 1'b0;
        end else if (!div_ready_i) begin
            if (dcnt == ((div_op2_o == 32'd0) ? 6'd2 : 6'd34)) begin
                div_ready_i  <= 1'b1;
                div_result_i <= {r_m, q_m};
            end
            dcnt <= dcnt + 6'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues a divide, counts stalled cycles, checks the DONE and following IDLE cycle.
    task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stalls,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   stalls;
        logic start_c1;
        logic start_commit;
        stalls       = 0;
        start_c1     = 1'b0;
        start_commit = 1'b0;
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        #1;
        while (stall_o && stalls < 100) begin
            if (stalls == 1) start_c1 = div_start_o;
            if (div_ready_i) start_commit = div_start_o;
            stalls++;
            tick();
            #1;
        end
        chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
        chk({tag, " start_cycle1"}, {63'd0, start_c1}, 64'd1);
        chk({tag, " start_at_commit"}, {63'd0, start_commit}, 64'd1);
        chk({tag, " signed_mode"}, {63'd0, div_signed_o}, {63'd0, o == 3'd3});
        // DONE cycle: DIV still held on op, must not re-issue
        chk({tag, " done_start"}, {63'd0, div_start_o}, 64'd0);
        chk({tag, " hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        chk({tag, " lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        tick();
        op_valid = 1'b0;
        #1;
        chk({tag, " no_reissue"}, {63'd0, div_start_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a DIV presented to confirm no stall while in reset
        tick();
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd7; rt_data = 32'd1;
        #1;
        chk("reset stall", {63'd0, stall_o}, 64'd0);
        tick();
        chk("reset hi", {32'd0, hi_o}, 64'd0);
        chk("reset lo", {32'd0, lo_o}, 64'd0);
        chk("reset start", {63'd0, div_start_o}, 64'd0);
        op_valid = 1'b0;
        rst = 1'b1;

        // MULT / MULTU
        op_valid = 1'b1; op = 3'd1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
        #1;
        chk("mult stall", {63'd0, stall_o}, 64'd0);
        tick();
        op = 3'd2;
        #1;
        chk("mult hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("multu stall", {63'd0, stall_o}, 64'd0);
        tick();
        op_valid = 1'b0;
        chk("multu hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

        // Divides through the handshake
        run_div("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_100_7", 3'd4, 32'd100, 32'd7, 37, 32'd2, 32'd14);

        // Flush ten cycles into a DIV
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd50; rt_data = 32'd5;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("flush pre_stall", {63'd0, stall_o}, 64'd1);
        flush = 1'b1;
        #1;
        chk("flush stall", {63'd0, stall_o}, 64'd0);
        chk("flush annul", {63'd0, div_annul_o}, 64'd1);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flush start", {63'd0, div_start_o}, 64'd0);
        chk("flush idle_stall", {63'd0, stall_o}, 64'd0);
        chk("flush hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        op_valid = 1'b1; op = 3'd5; rs_data = 32'h1234_5678;
        tick();
        op_valid = 1'b0;
        chk("mthi hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
        chk("mthi lo", {32'd0, lo_o}, 64'd14);

        // Zero divisor, then a normal divide
        run_div("div_by_zero", 3'd3, 32'd9, 32'd0, 5, 32'd9, 32'hFFFF_FFFF);
        run_div("divu_9_3", 3'd4, 32'd9, 32'd3, 37, 32'd0, 32'd3);

        // Reset in the middle of a divide
        op_valid = 1'b1; op = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0; op_valid = 1'b0;
        tick();
        chk("midrst hilo", {hi_o, lo_o}, 64'd0);
        chk("midrst start", {63'd0, div_start_o}, 64'd0);
        chk("midrst stall", {63'd0, stall_o}, 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst idle", {63'd0, stall_o}, 64'd0);
        op_valid = 1'b1; op = 3'd6; rs_data = 32'd5;
        tick();
        op_valid = 1'b0;
        chk("mtlo lo", {32'd0, lo_o}, 64'd5);
        chk("mtlo hi", {32'd0, hi_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
